// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path: transmitter state encoding,
// the reference pattern and default widths used by the transmitter and detector.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEQ_1011  = 4'b1011;
    localparam int         SEQ_PAT_W = 4;
    localparam int         SEQ_CNT_W = 8;
    localparam int         SEQ_GAP_W = 4;

endpackage

// File: rtl/seq_dcount.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module seq_dcount #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with
// zero-filled gaps. States: IDLE wait | SHIFT pattern bits | GAP zero bits | DONE pulse.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W       = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN_RST = PAT_W'(SEQ_1011),
    parameter int               CNT_W       = SEQ_CNT_W,
    parameter int               GAP_W       = SEQ_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_n,
    output logic             xout,
    output logic             xvalid,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    seq_state_e       state_d, state_q;
    logic [PAT_W-1:0] pat_d, pat_q;
    logic [GAP_W-1:0] gap_len_d, gap_len_q;
    logic             xout_d, xout_q;
    logic             xvalid_d, xvalid_q;
    logic             frame_last_d, frame_last_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic             idx_load, idx_dec, idx_zero;
    logic             rep_load, rep_dec, rep_zero;
    logic             gap_load, gap_dec, gap_zero;
    logic [IDX_W-1:0] idx_cnt, idx_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;

    seq_dcount #(.W(IDX_W)) u_idx (
        .clk(clk), .rst(rst), .load(idx_load), .load_val(IDX_TOP),
        .dec(idx_dec), .cnt_o(idx_cnt), .zero_o(idx_zero)
    );

    seq_dcount #(.W(CNT_W)) u_rep (
        .clk(clk), .rst(rst), .load(rep_load), .load_val(repeat_n),
        .dec(rep_dec), .cnt_o(rep_cnt), .zero_o(rep_zero)
    );

    seq_dcount #(.W(GAP_W)) u_gap (
        .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_len_q),
        .dec(gap_dec), .cnt_o(gap_cnt), .zero_o(gap_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pat_q        <= PATTERN_RST;
            gap_len_q    <= '0;
            xout_q       <= 1'b0;
            xvalid_q     <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            gap_len_q    <= gap_len_d;
            xout_q       <= xout_d;
            xvalid_q     <= xvalid_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Zero-flag terms only guard against a counter already drained; normal exits hit count 1.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        gap_len_d = gap_len_q;
        idx_load  = 1'b0;
        idx_dec   = 1'b0;
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (repeat_n != '0) begin
                        state_d   = SHIFT;
                        pat_d     = pat_in;
                        gap_len_d = gap_n;
                        idx_load  = 1'b1;
                        rep_load  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (idx_zero) begin
                    rep_dec = 1'b1;
                    if ((rep_cnt == CNT_W'(1)) || rep_zero) begin
                        state_d = DONE;
                    end else if (gap_len_q != '0) begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end else begin
                        idx_load = 1'b1;
                    end
                end else begin
                    idx_dec = 1'b1;
                end
            end
            GAP: begin
                if ((gap_cnt == GAP_W'(1)) || gap_zero) begin
                    state_d  = SHIFT;
                    idx_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-cycle state so they can be registered without latency.
    always_comb begin
        idx_nxt      = idx_load ? IDX_TOP : (idx_dec ? (idx_cnt - IDX_W'(1)) : idx_cnt);
        xvalid_d     = (state_d == SHIFT) || (state_d == GAP);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        xout_d       = 1'b0;
        frame_last_d = 1'b0;
        if (state_d == SHIFT) begin
            xout_d       = pat_d[idx_nxt];
            frame_last_d = (idx_nxt == '0);
        end
    end

    assign xout       = xout_q;
    assign xvalid     = xvalid_q;
    assign frame_last = frame_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: requests queue the expected bit stream,
// a negedge monitor pops and compares whenever the line is valid or done pulses.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pat_in;
    logic [7:0] repeat_n;
    logic [3:0] gap_n;
    logic       xout, xvalid, frame_last, busy, done;

    typedef struct packed {
        logic xout;
        logic last;
    } bit_t;

    bit_t exp_q[$];
    logic done_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_fl = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in),
        .repeat_n(repeat_n), .gap_n(gap_n), .xout(xout), .xvalid(xvalid),
        .frame_last(frame_last), .busy(busy), .done(done)
    );

    always @(negedge clk) begin
        bit_t e;
        logic d;
        checks++;
        if (xvalid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid t=%0t xout=%b expected no valid bit", $time, xout);
            end else begin
                e = exp_q.pop_front();
                if (xout !== e.xout || frame_last !== e.last || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bit t=%0t got xout=%b last=%b busy=%b expected xout=%b last=%b busy=1",
                             $time, xout, frame_last, busy, e.xout, e.last);
                end
            end
        end else if (frame_last !== 1'b0) begin
            errors++;
            $display("FAIL last_without_valid t=%0t frame_last=%b expected 0", $time, frame_last);
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done t=%0t done=1 expected 0", $time);
            end else begin
                d = done_q.pop_front();
                if (prev_fl !== d || xvalid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_timing t=%0t prev_last=%b xvalid=%b busy=%b expected prev_last=%b xvalid=0 busy=1",
                             $time, prev_fl, xvalid, busy, d);
                end
            end
        end
        prev_fl = frame_last;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse (accepted at the next edge) and returns 1 ns after that edge.
    task automatic req(input logic [3:0] p, input logic [7:0] rn, input logic [3:0] gn);
        bit_t b;
        for (int r = 0; r < int'(rn); r++) begin
            for (int i = 3; i >= 0; i--) begin
                b.xout = p[i];
                b.last = (i == 0);
                exp_q.push_back(b);
            end
            if (r < int'(rn) - 1) begin
                for (int g = 0; g < int'(gn); g++) begin
                    b.xout = 1'b0;
                    b.last = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
        done_q.push_back(rn != 0);
        start    = 1'b1;
        pat_in   = p;
        repeat_n = rn;
        gap_n    = gn;
        step();
        start    = 1'b0;
        pat_in   = ~p;
        repeat_n = 8'd7;
        gap_n    = 4'd9;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout t=%0t pending_bits=%0d pending_done=%0d expected 0",
                     name, $time, exp_q.size(), done_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; pat_in = 4'b0110; repeat_n = 8'd3; gap_n = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", {27'd0, xout, xvalid, frame_last, busy, done}, 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", {30'd0, xvalid, busy}, 32'd0);
        end

        // Single frame: first bit one cycle after the accept edge.
        req(4'b1011, 8'd1, 4'd0);
        chk("first_bit", {29'd0, xvalid, xout, busy}, 32'b111);
        wait_idle("single", 20);
        step();

        // 1011 00 1011 00 1011
        req(4'b1011, 8'd3, 4'd2);
        wait_idle("repeat_gap", 40);
        step();

        // 10111011 back-to-back, with a start pulse mid-request that must be ignored.
        req(4'b1011, 8'd2, 4'd0);
        step();
        start = 1'b1; pat_in = 4'b1111; repeat_n = 8'd4; gap_n = 4'd3;
        step(); step(); step();
        start = 1'b0;
        wait_idle("back_to_back", 30);
        step();

        // repeat_n=0: done right after accept, next start accepted in first IDLE cycle.
        req(4'b1011, 8'd0, 4'd5);
        chk("zero_repeat_done", {30'd0, done, xvalid}, 32'b10);
        step();
        req(4'b0110, 8'd1, 4'd0);
        chk("restart_after_done", {30'd0, xvalid, xout}, 32'b10);
        wait_idle("zero_repeat", 20);
        step();

        req(4'b0001, 8'd3, 4'd15);
        wait_idle("max_gap", 80);
        step();
        req(4'b1100, 8'd255, 4'd15);
        wait_idle("max_repeat", 6000);
        step();

        // Abort during the second bit of a 5-repeat request.
        req(4'b1011, 8'd5, 4'd1);
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        done_q.delete();
        chk("abort_outputs", {27'd0, xout, xvalid, frame_last, busy, done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_stays_idle", {29'd0, xvalid, busy, done}, 32'd0);
        req(4'b1001, 8'd2, 4'd1);
        wait_idle("after_abort", 30);
        step(); step();

        chk("leftover_bits", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
